// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the single-port memory.
// The arbiter uses the slave view; the pipeline/memory environment uses the master view.
interface unified_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  inst_ren;
   logic [ADDR_WIDTH-1:0] inst_addr;
   logic                  inst_flush;
   logic [DATA_WIDTH-1:0] inst_data;
   logic                  inst_ready;

   logic                  mem_ren;
   logic                  mem_wen;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_dout;
   logic [DATA_WIDTH-1:0] mem_din;
   logic                  mem_ready;

   logic                  ram_req;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  ram_ack;

   logic                  bus_err;
   logic                  if_stall;
   logic                  mem_stall;

   modport slave (
      input  inst_ren, inst_addr, inst_flush,
      input  mem_ren, mem_wen, mem_addr, mem_dout,
      input  ram_rdata, ram_ack,
      output inst_data, inst_ready,
      output mem_din, mem_ready,
      output ram_req, ram_we, ram_addr, ram_wdata,
      output bus_err, if_stall, mem_stall
   );

   modport master (
      output inst_ren, inst_addr, inst_flush,
      output mem_ren, mem_wen, mem_addr, mem_dout,
      output ram_rdata, ram_ack,
      input  inst_data, inst_ready,
      input  mem_din, mem_ready,
      input  ram_req, ram_we, ram_addr, ram_wdata,
      input  bus_err, if_stall, mem_stall
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins by default; a streak counter forces fetch through after MAX_DATA_STREAK contested data grants.
module unified_mem_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_DATA_STREAK = 4,
   parameter int TIMEOUT         = 64
) (
   input logic                  clk,
   input logic                  rst_n,
   unified_mem_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RESP_I,
      RESP_D
   } state_t;

   localparam int STREAK_W = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
   localparam int WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
   localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit TIMEOUT_EN = (TIMEOUT > 0);

   state_t                state_q, state_d;
   logic                  ram_req_q, ram_req_d;
   logic                  ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic [DATA_WIDTH-1:0] inst_data_q, inst_data_d;
   logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
   logic [STREAK_W-1:0]   streak_q, streak_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic                  drop_q, drop_d;
   logic                  bus_err_q, bus_err_d;

   logic data_pend;
   logic streak_ok;
   logic timeout_hit;
   logic drop_now;

   assign data_pend   = bus.mem_ren | bus.mem_wen;
   assign streak_ok   = (streak_q < STREAK_MAX);
   assign timeout_hit = TIMEOUT_EN && (wait_q == WAIT_LAST) && !bus.ram_ack;
   assign drop_now    = drop_q | bus.inst_flush;

   always_comb begin
      state_d     = state_q;
      ram_req_d   = ram_req_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      inst_data_d = inst_data_q;
      mem_din_d   = mem_din_q;
      streak_d    = streak_q;
      wait_d      = wait_q;
      drop_d      = drop_q;
      bus_err_d   = bus_err_q;

      unique case (state_q)
         IDLE: begin
            if (data_pend && (!bus.inst_ren || streak_ok)) begin
               state_d     = BUSY_D;
               ram_req_d   = 1'b1;
               ram_we_d    = bus.mem_wen;
               ram_addr_d  = bus.mem_addr;
               ram_wdata_d = bus.mem_dout;
               wait_d      = '0;
               // Only a grant that made fetch wait counts toward forcing fetch through.
               if (bus.inst_ren) begin
                  streak_d = streak_q + STREAK_W'(1);
               end
            end else if (bus.inst_ren) begin
               state_d     = BUSY_I;
               ram_req_d   = 1'b1;
               ram_we_d    = 1'b0;
               ram_addr_d  = bus.inst_addr;
               ram_wdata_d = '0;
               wait_d      = '0;
               streak_d    = '0;
               drop_d      = bus.inst_flush;
            end
         end

         BUSY_I, BUSY_D: begin
            if (bus.ram_ack || timeout_hit) begin
               ram_req_d = 1'b0;
               ram_we_d  = 1'b0;
               wait_d    = '0;
               if (timeout_hit) begin
                  bus_err_d = 1'b1;
               end
               if (state_q == BUSY_I) begin
                  // A redirected fetch finishes on the memory side but is never reported.
                  if (drop_now) begin
                     state_d = IDLE;
                     drop_d  = 1'b0;
                  end else begin
                     inst_data_d = bus.ram_ack ? bus.ram_rdata : '0;
                     state_d     = RESP_I;
                  end
               end else begin
                  if (!ram_we_q) begin
                     mem_din_d = bus.ram_ack ? bus.ram_rdata : '0;
                  end
                  state_d = RESP_D;
               end
            end else begin
               if (TIMEOUT_EN) begin
                  wait_d = wait_q + WAIT_W'(1);
               end
               if (state_q == BUSY_I) begin
                  drop_d = drop_now;
               end
            end
         end

         RESP_I, RESP_D: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ram_req_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         inst_data_q <= '0;
         mem_din_q   <= '0;
         streak_q    <= '0;
         wait_q      <= '0;
         drop_q      <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ram_req_q   <= ram_req_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         inst_data_q <= inst_data_d;
         mem_din_q   <= mem_din_d;
         streak_q    <= streak_d;
         wait_q      <= wait_d;
         drop_q      <= drop_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign bus.ram_req    = ram_req_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wdata  = ram_wdata_q;
   assign bus.inst_data  = inst_data_q;
   assign bus.mem_din    = mem_din_q;
   assign bus.bus_err    = bus_err_q;
   assign bus.inst_ready = (state_q == RESP_I);
   assign bus.mem_ready  = (state_q == RESP_D);
   assign bus.if_stall   = bus.inst_ren & ~bus.inst_ready;
   assign bus.mem_stall  = data_pend & ~bus.mem_ready;

endmodule
